// File: rtl/fifo_host.sv
// Burst requester for the 8-deep FIFO: one wr_en/rd_en per two cycles, checks ack/err flags and reports done/err/count.
// A burst of len words takes 2*len cycles plus one DONE cycle; full/empty stalls abort after WAIT_MAX cycles.
module fifo_host #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int WAIT_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [3:0]        cmd_len,
    input  logic [DATA_W-1:0] cmd_base,
    output logic              fifo_wr_en,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] fifo_din,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic              fifo_wr_ack,
    input  logic              fifo_wr_err,
    input  logic              fifo_rd_ack,
    input  logic              fifo_rd_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              done,
    output logic              err,
    output logic [3:0]        xfer_count
);
    localparam int         WCW     = $clog2(WAIT_MAX + 1);
    localparam logic [3:0] LEN_MAX = 4'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_CHECK, RD_ISSUE, RD_CHECK, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        len_q, len_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [3:0]        xfer_count_q, xfer_count_d;
    logic              err_q, err_d;
    logic [WCW-1:0]    wait_q, wait_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_vld_q, rd_vld_d;
    logic [3:0]        len_clamped;

    assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        base_d       = base_q;
        xfer_count_d = xfer_count_q;
        err_d        = err_q;
        wait_d       = wait_q;
        rd_data_d    = rd_data_q;
        rd_vld_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    len_d        = len_clamped;
                    base_d       = cmd_base;
                    xfer_count_d = '0;
                    err_d        = 1'b0;
                    wait_d       = '0;
                    if (len_clamped == 4'd0) state_d = DONE;
                    else if (cmd_rw)         state_d = RD_ISSUE;
                    else                     state_d = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                if (!fifo_full) begin
                    state_d = WR_CHECK;
                end else begin
                    wait_d = wait_q + WCW'(1);
                    if (wait_d == WCW'(WAIT_MAX)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WR_CHECK: begin
                // err wins over a simultaneous ack: the word is not counted
                if (fifo_wr_err || !fifo_wr_ack) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    xfer_count_d = xfer_count_q + 4'd1;
                    wait_d       = '0;
                    state_d      = (xfer_count_d == len_q) ? DONE : WR_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (!fifo_empty) begin
                    state_d = RD_CHECK;
                end else begin
                    wait_d = wait_q + WCW'(1);
                    if (wait_d == WCW'(WAIT_MAX)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RD_CHECK: begin
                if (fifo_rd_err || !fifo_rd_ack) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    xfer_count_d = xfer_count_q + 4'd1;
                    wait_d       = '0;
                    rd_data_d    = fifo_dout;
                    rd_vld_d     = 1'b1;
                    state_d      = (xfer_count_d == len_q) ? DONE : RD_ISSUE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            base_q       <= '0;
            xfer_count_q <= '0;
            err_q        <= 1'b0;
            wait_q       <= '0;
            rd_data_q    <= '0;
            rd_vld_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            base_q       <= base_d;
            xfer_count_q <= xfer_count_d;
            err_q        <= err_d;
            wait_q       <= wait_d;
            rd_data_q    <= rd_data_d;
            rd_vld_q     <= rd_vld_d;
        end
    end

    // Ready is masked by reset so every output reads 0 while reset is held.
    assign cmd_ready     = (state_q == IDLE) && !reset;
    assign fifo_wr_en    = (state_q == WR_ISSUE) && !fifo_full;
    assign fifo_rd_en    = (state_q == RD_ISSUE) && !fifo_empty;
    assign fifo_din      = fifo_wr_en ? (base_q + DATA_W'(xfer_count_q)) : '0;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_vld_q;
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign xfer_count    = xfer_count_q;

endmodule

// File: tb/tb_fifo_host.sv
// Bench for fifo_host: behavioural 8-deep FIFO plus write/read scoreboards and directed bursts.
module tb_fifo_host;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_rw;
    logic [3:0]    cmd_len;
    logic [DW-1:0] cmd_base;
    logic          fifo_wr_en, fifo_rd_en;
    logic [DW-1:0] fifo_din, fifo_dout;
    logic          fifo_full, fifo_empty, fifo_wr_ack, fifo_wr_err, fifo_rd_ack, fifo_rd_err;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid, done, err;
    logic [3:0]    xfer_count;
    logic          force_rd_err;

    always #5 clk = ~clk;

    fifo_host #(.DATA_W(DW), .DEPTH(8), .WAIT_MAX(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_len(cmd_len), .cmd_base(cmd_base),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_din(fifo_din),
        .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_wr_ack(fifo_wr_ack), .fifo_wr_err(fifo_wr_err),
        .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .done(done),
        .err(err), .xfer_count(xfer_count)
    );

    // Behavioural FIFO: request sampled at posedge N, flags and dout valid during cycle N+1.
    logic [DW-1:0] mem [8];
    int            cnt, wp, rp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 0; wp <= 0; rp <= 0;
            fifo_wr_ack <= 1'b0; fifo_wr_err <= 1'b0;
            fifo_rd_ack <= 1'b0; fifo_rd_err <= 1'b0;
            fifo_dout <= '0;
        end else begin
            fifo_wr_ack <= 1'b0; fifo_wr_err <= 1'b0;
            fifo_rd_ack <= 1'b0; fifo_rd_err <= 1'b0;
            if (fifo_wr_en) begin
                if (cnt < 8) begin
                    mem[wp] <= fifo_din;
                    wp <= (wp + 1) % 8;
                    cnt <= cnt + 1;
                    fifo_wr_ack <= 1'b1;
                end else fifo_wr_err <= 1'b1;
            end else if (fifo_rd_en) begin
                if (force_rd_err || cnt == 0) fifo_rd_err <= 1'b1;
                else begin
                    fifo_dout <= mem[rp];
                    rp <= (rp + 1) % 8;
                    cnt <= cnt - 1;
                    fifo_rd_ack <= 1'b1;
                end
            end
        end
    end

    assign fifo_full  = (cnt == 8);
    assign fifo_empty = (cnt == 0);

    int            n_assert = 0;
    int            n_fail   = 0;
    int            n_wr = 0, n_rd = 0, n_done = 0;
    logic          last_empty;
    logic [DW-1:0] exp_wr [$];
    logic [DW-1:0] exp_rd [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One cycle; sample at negedge and run the scoreboards on whatever the DUT produced.
    task automatic step();
        @(negedge clk);
        if (fifo_wr_en) begin
            n_wr++;
            if (exp_wr.size() > 0) chk("wr_din", 64'(fifo_din), 64'(exp_wr.pop_front()));
            else                   chk("wr_unexpected", 64'(fifo_wr_en), 64'(0));
        end
        if (fifo_rd_en) n_rd++;
        if (fifo_rd_ack) last_empty = fifo_empty;
        if (rd_data_valid) begin
            if (exp_rd.size() > 0) chk("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
            else                   chk("rd_valid_unexpected", 64'(rd_data_valid), 64'(0));
        end
        if (done) n_done++;
    endtask

    task automatic send(input logic rw, input logic [3:0] len, input logic [DW-1:0] base);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_len   = len;
        cmd_base  = base;
    endtask

    // lat = number of negedge samples after the accept edge until done is seen.
    task automatic run(input int max, input bit poke, output int lat);
        lat = -1;
        for (int k = 1; k <= max; k++) begin
            step();
            if (k == 1) cmd_valid = 1'b0;
            if (poke) begin
                if (k == 2) begin cmd_valid = 1'b1; cmd_rw = ~cmd_rw; cmd_len = 4'd5; end
                if (k == 4) cmd_valid = 1'b0;
            end
            if (done) begin lat = k; break; end
        end
        if (lat < 0) chk("done_timeout", 64'(done), 64'(1));
    endtask

    task automatic finish_cmd(input int lat, input int exp_lat, input int xfer, input int errv, input int nd0);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("xfer_count", 64'(xfer_count), 64'(xfer));
        chk("err", 64'(err), 64'(errv));
        chk("sb_wr_left", 64'(exp_wr.size()), 64'(0));
        chk("sb_rd_left", 64'(exp_rd.size()), 64'(0));
        step();
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("ready_after_done", 64'(cmd_ready), 64'(1));
        chk("done_count", 64'(n_done - nd0), 64'(1));
        chk("xfer_hold", 64'(xfer_count), 64'(xfer));
    endtask

    initial begin
        int lat, nd0, nw0, nr0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_len = '0; cmd_base = '0;
        force_rd_err = 1'b0; last_empty = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_wr_en", 64'(fifo_wr_en), 64'(0));
        chk("rst_din", 64'(fifo_din), 64'(0));
        chk("rst_xfer", 64'(xfer_count), 64'(0));
        reset = 1'b0;
        step();
        chk("ready_after_reset", 64'(cmd_ready), 64'(1));

        // Reset in the second WR_CHECK of a 3-word write
        exp_wr.push_back(32'hA0); exp_wr.push_back(32'hA1);
        nd0 = n_done;
        send(1'b0, 4'd3, 32'hA0);
        step(); cmd_valid = 1'b0;
        step(); step(); step();
        chk("pre_rst_xfer", 64'(xfer_count), 64'(1));
        reset = 1'b1;
        #1;
        chk("async_rst_ready", 64'(cmd_ready), 64'(0));
        chk("async_rst_xfer", 64'(xfer_count), 64'(0));
        chk("async_rst_wr_en", 64'(fifo_wr_en), 64'(0));
        chk("async_rst_done", 64'(done), 64'(0));
        step(); step();
        reset = 1'b0;
        step(); step();
        chk("rst_release_ready", 64'(cmd_ready), 64'(1));
        chk("rst_no_done", 64'(n_done - nd0), 64'(0));
        chk("rst_sb_wr", 64'(exp_wr.size()), 64'(0));

        // Write 3 from 0x10, with a command poked while busy
        for (int i = 0; i < 3; i++) exp_wr.push_back(32'h10 + i);
        nd0 = n_done; nr0 = n_rd;
        send(1'b0, 4'd3, 32'h10);
        run(40, 1'b1, lat);
        finish_cmd(lat, 7, 3, 0, nd0);
        step(); step();
        chk("busy_cmd_ignored", 64'(n_rd - nr0), 64'(0));

        // Read the 3 back; last ack drains to empty
        for (int i = 0; i < 3; i++) exp_rd.push_back(32'h10 + i);
        nd0 = n_done; last_empty = 1'b0;
        send(1'b1, 4'd3, 32'h0);
        run(40, 1'b0, lat);
        step();
        chk("rd_latency", 64'(lat), 64'(7));
        chk("rd_xfer", 64'(xfer_count), 64'(3));
        chk("rd_err", 64'(err), 64'(0));
        chk("rd_sb_left", 64'(exp_rd.size()), 64'(0));
        chk("empty_at_last_ack", 64'(last_empty), 64'(1));
        chk("rd_done_count", 64'(n_done - nd0), 64'(1));

        // Fill to 6, then write 4: two acks then a 16-cycle full stall
        for (int i = 0; i < 6; i++) exp_wr.push_back(32'h100 + i);
        nd0 = n_done;
        send(1'b0, 4'd6, 32'h100);
        run(40, 1'b0, lat);
        finish_cmd(lat, 13, 6, 0, nd0);
        exp_wr.push_back(32'h200); exp_wr.push_back(32'h201);
        nd0 = n_done;
        send(1'b0, 4'd4, 32'h200);
        run(60, 1'b0, lat);
        finish_cmd(lat, 21, 2, 1, nd0);

        // Drain all 8
        for (int i = 0; i < 6; i++) exp_rd.push_back(32'h100 + i);
        exp_rd.push_back(32'h200); exp_rd.push_back(32'h201);
        nd0 = n_done;
        send(1'b1, 4'd8, 32'h0);
        run(60, 1'b0, lat);
        finish_cmd(lat, 17, 8, 0, nd0);

        // Forced rd_err on first read check
        exp_wr.push_back(32'h300); exp_wr.push_back(32'h301);
        nd0 = n_done;
        send(1'b0, 4'd2, 32'h300);
        run(40, 1'b0, lat);
        finish_cmd(lat, 5, 2, 0, nd0);
        force_rd_err = 1'b1;
        nd0 = n_done; nr0 = n_rd;
        send(1'b1, 4'd2, 32'h0);
        run(40, 1'b0, lat);
        force_rd_err = 1'b0;
        finish_cmd(lat, 3, 0, 1, nd0);
        chk("rd_err_one_req", 64'(n_rd - nr0), 64'(1));

        // Zero-length command clears err and touches nothing
        nd0 = n_done; nw0 = n_wr; nr0 = n_rd;
        send(1'b0, 4'd0, 32'h55);
        run(20, 1'b0, lat);
        finish_cmd(lat, 1, 0, 0, nd0);
        chk("len0_no_wr", 64'(n_wr - nw0), 64'(0));
        chk("len0_no_rd", 64'(n_rd - nr0), 64'(0));

        // Drain the two words left by the failed read
        exp_rd.push_back(32'h300); exp_rd.push_back(32'h301);
        nd0 = n_done; last_empty = 1'b0;
        send(1'b1, 4'd2, 32'h0);
        run(40, 1'b0, lat);
        finish_cmd(lat, 5, 2, 0, nd0);
        chk("drain_empty", 64'(last_empty), 64'(1));

        // Length 12 clamps to 8
        for (int i = 0; i < 8; i++) exp_wr.push_back(32'h400 + i);
        nd0 = n_done; nw0 = n_wr;
        send(1'b0, 4'd12, 32'h400);
        run(60, 1'b0, lat);
        finish_cmd(lat, 17, 8, 0, nd0);
        chk("clamp_wr_count", 64'(n_wr - nw0), 64'(8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
